// File: rtl/host_mem_writer.sv
// Byte-stream command parser that turns host bursts into single-cycle,
// active-low write strobes for the character row buffer, palette and font memory.
module host_mem_writer #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  host_data,
  input  logic        host_valid,
  output logic        host_ready,
  output logic        chrowbuf_wr,
  output logic [7:0]  chrowbuf_wr_addr,
  output logic [15:0] chrowbuf_wr_data,
  output logic        palette_wr,
  output logic [7:0]  palette_wr_addr,
  output logic [15:0] palette_wr_data,
  output logic        fontmem_wr,
  output logic [11:0] fontmem_wr_addr,
  output logic [7:0]  fontmem_wr_data,
  output logic        err
);

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] T_CHROW = 2'd0;
  localparam logic [1:0] T_PAL   = 2'd1;
  localparam logic [1:0] T_FONT  = 2'd2;
  localparam logic [1:0] T_RSVD  = 2'd3;

  typedef enum logic [2:0] {
    S_CMD, S_ADDR_HI, S_ADDR_LO, S_DATA_HI, S_DATA_LO, S_WRITE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    target_q, target_d;
  logic [5:0]    count_q, count_d;
  logic [11:0]   addr_q, addr_d;
  logic [7:0]    data_hi_q, data_hi_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;
  logic          cw_q, cw_d, pw_q, pw_d, fw_q, fw_d;
  logic [7:0]    caddr_q, caddr_d, paddr_q, paddr_d;
  logic [15:0]   cdata_q, cdata_d, pdata_q, pdata_d;
  logic [11:0]   faddr_q, faddr_d;
  logic [7:0]    fdata_q, fdata_d;
  logic          accept;
  logic          is_font;

  assign accept  = host_valid && ready_q;
  assign is_font = (target_q == T_FONT);

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    count_d   = count_q;
    addr_d    = addr_q;
    data_hi_d = data_hi_q;
    idle_d    = '0;
    err_d     = 1'b0;
    cw_d      = 1'b1;
    pw_d      = 1'b1;
    fw_d      = 1'b1;
    caddr_d   = caddr_q;
    cdata_d   = cdata_q;
    paddr_d   = paddr_q;
    pdata_d   = pdata_q;
    faddr_d   = faddr_q;
    fdata_d   = fdata_q;

    case (state_q)
      S_CMD: begin
        if (accept) begin
          if (host_data[7:6] == T_RSVD) begin
            err_d = 1'b1;
          end else begin
            target_d = host_data[7:6];
            count_d  = host_data[5:0];
            addr_d   = '0;
            state_d  = (host_data[7:6] == T_FONT) ? S_ADDR_HI : S_ADDR_LO;
          end
        end
      end
      S_ADDR_HI: begin
        if (accept) begin
          addr_d[11:8] = host_data[3:0];
          state_d      = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (accept) begin
          addr_d[7:0] = host_data;
          state_d     = is_font ? S_DATA_LO : S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          data_hi_d = host_data;
          state_d   = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          state_d = S_WRITE;
          case (target_q)
            T_CHROW: begin
              cw_d    = 1'b0;
              caddr_d = addr_q[7:0];
              cdata_d = {data_hi_q, host_data};
            end
            T_PAL: begin
              pw_d    = 1'b0;
              paddr_d = addr_q[7:0];
              pdata_d = {data_hi_q, host_data};
            end
            default: begin
              fw_d    = 1'b0;
              faddr_d = addr_q;
              fdata_d = host_data;
            end
          endcase
        end
      end
      S_WRITE: begin
        // 8-bit targets wrap within their own 256-entry space
        addr_d = is_font ? addr_q + 12'd1 : {4'h0, addr_q[7:0] + 8'd1};
        if (count_q == 6'd0) begin
          state_d = S_CMD;
        end else begin
          count_d = count_q - 6'd1;
          state_d = is_font ? S_DATA_LO : S_DATA_HI;
        end
      end
      default: state_d = S_CMD;
    endcase

    if (state_q != S_CMD && state_q != S_WRITE && !accept) begin
      if (idle_q == IW'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        state_d = S_CMD;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end

    ready_d = (state_d != S_WRITE);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= S_CMD;
      target_q  <= T_CHROW;
      count_q   <= '0;
      addr_q    <= '0;
      data_hi_q <= '0;
      idle_q    <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      cw_q      <= 1'b1;
      pw_q      <= 1'b1;
      fw_q      <= 1'b1;
      caddr_q   <= '0;
      cdata_q   <= '0;
      paddr_q   <= '0;
      pdata_q   <= '0;
      faddr_q   <= '0;
      fdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      data_hi_q <= data_hi_d;
      idle_q    <= idle_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      cw_q      <= cw_d;
      pw_q      <= pw_d;
      fw_q      <= fw_d;
      caddr_q   <= caddr_d;
      cdata_q   <= cdata_d;
      paddr_q   <= paddr_d;
      pdata_q   <= pdata_d;
      faddr_q   <= faddr_d;
      fdata_q   <= fdata_d;
    end
  end

  assign host_ready       = ready_q;
  assign err              = err_q;
  assign chrowbuf_wr      = cw_q;
  assign chrowbuf_wr_addr = caddr_q;
  assign chrowbuf_wr_data = cdata_q;
  assign palette_wr       = pw_q;
  assign palette_wr_addr  = paddr_q;
  assign palette_wr_data  = pdata_q;
  assign fontmem_wr       = fw_q;
  assign fontmem_wr_addr  = faddr_q;
  assign fontmem_wr_data  = fdata_q;

endmodule

// File: doc/host_mem_writer.md
HOST_MEM_WRITER -- requirements
Module: host_mem_writer

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 255, idle cycles allowed between bytes of an incomplete command before abort.
REQ-002 SHALL have port: clk  input  1  system clock (40 MHz pixel clock domain).
REQ-003 SHALL have port: nrst  input  1  reset, synchronous, active-low; clock clk.
REQ-004 SHALL have port: host_data  input  8  command/address/data byte from host.
REQ-005 SHALL have port: host_valid  input  1  host_data valid, active-high.
REQ-006 SHALL have port: host_ready  output  1  byte accepted on an edge where host_valid and host_ready are both 1.
REQ-007 SHALL have ports: chrowbuf_wr  output  1 (active-low); chrowbuf_wr_addr  output  8; chrowbuf_wr_data  output  16.
REQ-008 SHALL have ports: palette_wr  output  1 (active-low); palette_wr_addr  output  8; palette_wr_data  output  16.
REQ-009 SHALL have ports: fontmem_wr  output  1 (active-low); fontmem_wr_addr  output  12; fontmem_wr_data  output  8.
REQ-010 SHALL have port: err  output  1  one-cycle error pulse, active-high.

Function
REQ-011 Command byte SHALL be {target[7:6], count_m1[5:0]}: target 00=chrowbuf, 01=palette, 10=fontmem, 11=reserved; word count = count_m1+1 (1..64).
REQ-012 Address bytes SHALL follow: one byte for chrowbuf/palette; two bytes for fontmem (first byte bits[3:0] = addr[11:8], bits[7:4] ignored; second byte = addr[7:0]).
REQ-013 Data SHALL follow: 16-bit targets take two bytes per word, high byte first; fontmem takes one byte per word.
REQ-014 FSM states SHALL be CMD, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, WRITE; CMD->ADDR_HI (fontmem) or ADDR_LO (others); ADDR_HI->ADDR_LO; ADDR_LO->DATA_HI (16-bit) or DATA_LO (fontmem); DATA_HI->DATA_LO; DATA_LO->WRITE.
REQ-015 On the edge accepting a word's final byte, the FSM SHALL enter WRITE and drive the target's strobe low with its addr/data registered on that same edge.
REQ-016 The strobe SHALL be low for exactly one cycle; host_ready SHALL be 0 during WRITE; host_valid in WRITE SHALL be ignored.
REQ-017 On leaving WRITE the strobe SHALL return high, address SHALL increment modulo its width (8 or 12 bits), remaining count SHALL decrement; next state DATA_HI/DATA_LO if words remain, else CMD.
REQ-018 Only the selected target's strobe SHALL ever go low; the other strobes SHALL stay 1.
REQ-019 addr/data outputs SHALL hold their last values when not writing.
REQ-020 A reserved-target command byte SHALL be discarded, pulse err for one cycle on the following cycle, and remain in CMD.
REQ-021 In any state other than CMD and WRITE, an idle counter SHALL count cycles without an accepted byte, clear on each accept; reaching TIMEOUT SHALL pulse err for one cycle and return to CMD with no write.
REQ-022 host_ready SHALL be 1 in all states except WRITE and reset.

Reset
REQ-023 While nrst=0 on an edge: state CMD, host_ready=0, all strobes=1, all addr/data=0, err=0, idle counter=0, partial word discarded.
REQ-024 host_ready SHALL be 1 on the first cycle after nrst returns to 1.
REQ-025 Reset asserted mid-command SHALL abort it with no strobe issued.

Verification
REQ-026 Chrowbuf burst: bytes 0x01,0x10,0xAB,0xCD,0x12,0x34 -> chrowbuf_wr low twice: addr 0x10 data 0xABCD, then addr 0x11 data 0x1234; host_ready 0 in each strobe cycle; end in CMD.
REQ-027 Palette wrap: 0x41,0xFF,0x0F,0x00,0x00,0xF0 -> palette_wr at addr 0xFF data 0x0F00, then addr 0x00 data 0x00F0.
REQ-028 Fontmem: 0x80,0xFA,0xBC,0x5A -> one fontmem_wr low cycle, addr 0xABC, data 0x5A; chrowbuf_wr and palette_wr stay 1.
REQ-029 Reserved: 0xC3 then 0x00,0x20,0x12,0x34 -> one err pulse, no strobe for 0xC3; 0x00 parsed as new command, chrowbuf addr 0x20 data 0x1234 written.
REQ-030 Timeout: 0x00,0x05 then host_valid=0 for TIMEOUT cycles -> err pulse exactly once, no strobe; next byte 0x40 treated as command.
REQ-031 Reset mid-word: 0x00,0x05,0xAA then nrst=0 one cycle -> no strobe, all outputs at reset values; next 0x00,0x06,0x11,0x22 writes chrowbuf addr 0x06 data 0x1122.
